// File: rtl/fwrisc_exec_formal_arith_stim_pkg.sv
// Shared constants for the exec-unit arithmetic stimulus: op-type/ALU codes,
// the issue-order op table and the operand LFSR step function.
package fwrisc_exec_formal_arith_stim_pkg;

    localparam logic [4:0] OP_TYPE_ARITH = 5'd1;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_AND = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_CLR = 6'd4;
    localparam logic [5:0] OP_EQ  = 6'd5;
    localparam logic [5:0] OP_LT  = 6'd7;
    localparam logic [5:0] OP_LTU = 6'd9;
    localparam logic [5:0] OP_OPA = 6'd11;
    localparam logic [5:0] OP_OPB = 6'd12;
    localparam logic [5:0] OP_XOR = 6'd13;

    localparam int          N_TABLE   = 11;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    // Issue order of ALU ops; the caller keeps idx in 0..N_TABLE-1.
    function automatic logic [5:0] alu_op_for(input logic [3:0] idx);
        logic [5:0] op;
        case (idx)
            4'd0:    op = OP_ADD;
            4'd1:    op = OP_SUB;
            4'd2:    op = OP_AND;
            4'd3:    op = OP_OR;
            4'd4:    op = OP_CLR;
            4'd5:    op = OP_EQ;
            4'd6:    op = OP_LT;
            4'd7:    op = OP_LTU;
            4'd8:    op = OP_XOR;
            4'd9:    op = OP_OPA;
            default: op = OP_OPB;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/fwrisc_exec_formal_lfsr32.sv
// Operand LFSR; each advance steps twice so one load consumes op_a and op_b.
module fwrisc_exec_formal_lfsr32
    import fwrisc_exec_formal_arith_stim_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] state
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (adv) begin
            state <= lfsr_next(lfsr_next(state));
        end
    end

endmodule

// File: rtl/fwrisc_exec_formal_arith_stim.sv
// Initiator that feeds a bounded stream of arithmetic instructions to the exec
// unit, holding each until instr_complete and flagging timeouts/stray completions.
module fwrisc_exec_formal_arith_stim
    import fwrisc_exec_formal_arith_stim_pkg::*;
#(
    parameter int          N_INSTR = 4,
    parameter logic [31:0] SEED    = 32'h00000001,
    parameter int          TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        decode_valid,
    output logic        instr_c,
    output logic [4:0]  op_type,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [5:0]  op,
    output logic [31:0] op_c,
    output logic [5:0]  rd,
    input  logic        instr_complete,
    output logic        done,
    output logic        timeout,
    output logic        protocol_err,
    output logic [7:0]  instr_count
);

    localparam logic [7:0] N_INSTR_C = 8'(N_INSTR);
    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    state_e      state;
    logic [3:0]  op_idx;
    logic [4:0]  rd_idx;
    logic [7:0]  wait_cnt;
    logic [31:0] lfsr_state;
    logic        load;

    assign instr_c = 1'b0;
    assign op_c    = 32'h0;

    // Fields are loaded (and the LFSR consumed) on leaving IDLE or a non-final GAP.
    assign load = (state == S_IDLE) || ((state == S_GAP) && (instr_count != N_INSTR_C));

    fwrisc_exec_formal_lfsr32 u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (SEED),
        .adv   (load),
        .state (lfsr_state)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            decode_valid <= 1'b0;
            op_type      <= 5'd0;
            op_a         <= 32'h0;
            op_b         <= 32'h0;
            op           <= 6'd0;
            rd           <= 6'd0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            protocol_err <= 1'b0;
            instr_count  <= 8'd0;
            op_idx       <= 4'd0;
            rd_idx       <= 5'd0;
            wait_cnt     <= 8'd0;
        end else begin
            if (instr_complete && (state != S_WAIT)) begin
                protocol_err <= 1'b1;
            end

            if (load) begin
                decode_valid <= 1'b1;
                op_type      <= OP_TYPE_ARITH;
                op           <= alu_op_for(op_idx);
                rd           <= {1'b0, rd_idx + 5'd1};
                op_a         <= lfsr_state;
                op_b         <= lfsr_next(lfsr_state);
                wait_cnt     <= 8'd0;
                state        <= S_WAIT;
            end

            case (state)
                S_WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (instr_complete) begin
                        decode_valid <= 1'b0;
                        if (instr_count != 8'hFF) begin
                            instr_count <= instr_count + 8'd1;
                        end
                        op_idx <= (op_idx == 4'(N_TABLE - 1)) ? 4'd0 : op_idx + 4'd1;
                        rd_idx <= (rd_idx == 5'd30) ? 5'd0 : rd_idx + 5'd1;
                        state  <= S_GAP;
                    end else if (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_C) begin
                        decode_valid <= 1'b0;
                        timeout      <= 1'b1;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (instr_count == N_INSTR_C) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    decode_valid <= 1'b0;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
